// File: rtl/avalon_sdram_arbiter.sv
// avalon_sdram_arbiter: N-host Avalon-MM arbiter in front of one SDRAM agent.
// A grant is held for a complete burst: write beats are counted as the agent
// accepts them, read beats are counted as readdatavalid returns. Arbitration
// is either round-robin or fixed priority (lowest index wins).
module avalon_sdram_arbiter #(
   parameter int NUM_HOSTS = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 16,
   parameter int BURST_W   = 6,
   parameter int RR_MODE   = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_HOSTS*ADDR_W-1:0]    h_address,
   input  logic [NUM_HOSTS-1:0]           h_read,
   input  logic [NUM_HOSTS-1:0]           h_write,
   input  logic [NUM_HOSTS*DATA_W-1:0]    h_writedata,
   input  logic [NUM_HOSTS*DATA_W/8-1:0]  h_byteenable,
   input  logic [NUM_HOSTS*BURST_W-1:0]   h_burstcount,
   output logic [NUM_HOSTS-1:0]           h_waitrequest,
   output logic [DATA_W-1:0]              h_readdata,
   output logic [NUM_HOSTS-1:0]           h_readdatavalid,
   output logic [ADDR_W-1:0]              m_address,
   output logic                           m_read,
   output logic                           m_write,
   output logic [DATA_W-1:0]              m_writedata,
   output logic [DATA_W/8-1:0]            m_byteenable,
   output logic [BURST_W-1:0]             m_burstcount,
   input  logic                           m_waitrequest,
   input  logic [DATA_W-1:0]              m_readdata,
   input  logic                           m_readdatavalid,
   output logic [$clog2(NUM_HOSTS)-1:0]   grant_id,
   output logic                           busy
);

   localparam int GW   = $clog2(NUM_HOSTS);
   localparam int BE_W = DATA_W / 8;
   localparam int CW   = BURST_W + 1;   // one extra bit so a full burst never wraps
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_CMD, READ_DATA} state_t;

   state_t               state, state_nxt;
   logic [GW-1:0]        rr_ptr, winner, win_lo, win_hi;
   logic                 found_hi;
   logic [NUM_HOSTS-1:0] req;
   logic [CW-1:0]        beat_cnt, beat_len, cnt_inc;
   logic                 last_beat, wr_accept, rd_accept;

   logic                 win_write;
   logic [BURST_W-1:0]   win_bc;
   logic                 own_read, own_write;
   logic [ADDR_W-1:0]    own_address;
   logic [DATA_W-1:0]    own_writedata;
   logic [BE_W-1:0]      own_byteenable;
   logic [BURST_W-1:0]   own_bc;

   assign busy       = (state != IDLE);
   assign h_readdata = m_readdata;
   assign cnt_inc    = beat_cnt + ONE;
   assign last_beat  = (cnt_inc == beat_len);
   assign wr_accept  = m_write & ~m_waitrequest;
   assign rd_accept  = m_read & ~m_waitrequest;

   // Pick the winner: lowest requester at or above the RR pointer, else lowest overall.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      req      = h_read | h_write;
      win_lo   = '0;
      win_hi   = '0;
      found_hi = 1'b0;
      for (int i = NUM_HOSTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_lo = GW'(i);
            if (GW'(i) >= rr_ptr) begin
               win_hi   = GW'(i);
               found_hi = 1'b1;
            end
         end
      end
      winner = (RR_MODE != 0 && found_hi) ? win_hi : win_lo;
   end

   // Slice out the current owner's and the candidate winner's request fields.
   always_comb begin
      own_read       = 1'b0;
      own_write      = 1'b0;
      own_address    = '0;
      own_writedata  = '0;
      own_byteenable = '0;
      own_bc         = '0;
      win_write      = 1'b0;
      win_bc         = '0;
      for (int i = 0; i < NUM_HOSTS; i++) begin
         if (GW'(i) == grant_id) begin
            own_read       = h_read[i];
            own_write      = h_write[i];
            own_address    = h_address[i*ADDR_W +: ADDR_W];
            own_writedata  = h_writedata[i*DATA_W +: DATA_W];
            own_byteenable = h_byteenable[i*BE_W +: BE_W];
            own_bc         = h_burstcount[i*BURST_W +: BURST_W];
         end
         if (GW'(i) == winner) begin
            win_write = h_write[i];
            win_bc    = h_burstcount[i*BURST_W +: BURST_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: a grant lasts until the final beat of its burst is transferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (|req) state_nxt = win_write ? WRITE_BURST : READ_CMD;
         WRITE_BURST: if (wr_accept && last_beat) state_nxt = IDLE;
         READ_CMD:    if (rd_accept) state_nxt = READ_DATA;
         READ_DATA:   if (m_readdatavalid && last_beat) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Grant, round-robin pointer and beat bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         beat_len <= '0;
      end else begin
         case (state)
            IDLE: if (|req) begin
               grant_id <= winner;
               rr_ptr   <= (int'(winner) == NUM_HOSTS - 1) ? '0 : winner + GW'(1);
               beat_cnt <= '0;
               beat_len <= (win_bc == '0) ? ONE : {1'b0, win_bc};
            end
            WRITE_BURST: if (wr_accept) beat_cnt <= cnt_inc;
            READ_DATA:   if (m_readdatavalid) beat_cnt <= cnt_inc;
            default: ;
         endcase
      end
   end

   // Outputs: route the owner to the agent; everyone else is held off.
   always_comb begin
      h_waitrequest   = '1;
      h_readdatavalid = '0;
      m_address       = own_address;
      m_writedata     = own_writedata;
      m_byteenable    = own_byteenable;
      m_burstcount    = own_bc;
      m_read          = 1'b0;
      m_write         = 1'b0;
      case (state)
         WRITE_BURST: begin
            m_write                 = own_write;
            h_waitrequest[grant_id] = m_waitrequest;
         end
         READ_CMD: begin
            m_read                  = own_read;
            h_waitrequest[grant_id] = m_waitrequest;
         end
         READ_DATA: h_readdatavalid[grant_id] = m_readdatavalid;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
// Bench for avalon_sdram_arbiter: table of single-host transactions plus
// directed sequences (stalls/gaps, RR vs fixed order, reset mid-read).
// A small SDRAM model answers reads; a scoreboard checks every beat.
module tb_avalon_sdram_arbiter;

   localparam int N   = 3;
   localparam int AW  = 32;
   localparam int DW  = 16;
   localparam int BW  = 6;
   localparam int BEW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N*AW-1:0]  h_address;
   logic [N-1:0]     h_read, h_write;
   logic [N*DW-1:0]  h_writedata;
   logic [N*BEW-1:0] h_byteenable;
   logic [N*BW-1:0]  h_burstcount;
   logic             m_waitrequest, m_readdatavalid;
   logic [DW-1:0]    m_readdata;

   logic [N-1:0]     h_waitrequest, h_readdatavalid;
   logic [DW-1:0]    h_readdata;
   logic [AW-1:0]    m_address;
   logic             m_read, m_write, busy;
   logic [DW-1:0]    m_writedata;
   logic [BEW-1:0]   m_byteenable;
   logic [BW-1:0]    m_burstcount;
   logic [1:0]       grant_id;

   logic [N-1:0]     fp_h_waitrequest, fp_h_readdatavalid;
   logic [DW-1:0]    fp_h_readdata;
   logic [AW-1:0]    fp_m_address;
   logic             fp_m_read, fp_m_write, fp_busy;
   logic [DW-1:0]    fp_m_writedata;
   logic [BEW-1:0]   fp_m_byteenable;
   logic [BW-1:0]    fp_m_burstcount;
   logic [1:0]       fp_grant_id;

   avalon_sdram_arbiter #(.NUM_HOSTS(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RR_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .h_address(h_address), .h_read(h_read), .h_write(h_write), .h_writedata(h_writedata),
      .h_byteenable(h_byteenable), .h_burstcount(h_burstcount),
      .h_waitrequest(h_waitrequest), .h_readdata(h_readdata), .h_readdatavalid(h_readdatavalid),
      .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_burstcount(m_burstcount),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .grant_id(grant_id), .busy(busy));

   avalon_sdram_arbiter #(.NUM_HOSTS(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RR_MODE(0)) dut_fp (
      .clk(clk), .rst(rst),
      .h_address(h_address), .h_read(h_read), .h_write(h_write), .h_writedata(h_writedata),
      .h_byteenable(h_byteenable), .h_burstcount(h_burstcount),
      .h_waitrequest(fp_h_waitrequest), .h_readdata(fp_h_readdata), .h_readdatavalid(fp_h_readdatavalid),
      .m_address(fp_m_address), .m_read(fp_m_read), .m_write(fp_m_write), .m_writedata(fp_m_writedata),
      .m_byteenable(fp_m_byteenable), .m_burstcount(fp_m_burstcount),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .grant_id(fp_grant_id), .busy(fp_busy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   function automatic logic [DW-1:0] wdata(input int host, input int b);
      return DW'(32'hA000 + host * 256 + b);
   endfunction

   function automatic logic [DW-1:0] rdata(input logic [AW-1:0] addr, input int b);
      return DW'(int'(addr[15:0]) + b);
   endfunction

   function automatic logic [BEW-1:0] be_of(input int host);
      return BEW'(host + 1);
   endfunction

   // ---------------- SDRAM read model ----------------
   logic          sd_rdv = 1'b0, stray_rdv = 1'b0;
   logic [DW-1:0] sd_rdata = '0;
   assign m_readdatavalid = sd_rdv | stray_rdv;
   assign m_readdata      = sd_rdata;

   int            read_lat = 1;
   logic          cmd_seen = 1'b0;
   logic [AW-1:0] cmd_addr, sd_addr;
   logic [BW-1:0] cmd_bc;
   int            sd_delay = 0, sd_left = 0, sd_beat = 0;

   always @(negedge clk) begin
      cmd_seen = m_read && !m_waitrequest;
      cmd_addr = m_address;
      cmd_bc   = m_burstcount;
   end

   always @(posedge clk) begin
      #1;
      sd_rdv = 1'b0;
      if (cmd_seen) begin
         sd_addr  = cmd_addr;
         sd_left  = (cmd_bc == 0) ? 1 : int'(cmd_bc);
         sd_delay = read_lat;
         sd_beat  = 0;
         cmd_seen = 1'b0;
      end else if (sd_left > 0) begin
         if (sd_delay > 1) sd_delay--;
         else begin
            sd_rdv   = 1'b1;
            sd_rdata = rdata(sd_addr, sd_beat);
            sd_beat++;
            sd_left--;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { int host; logic [AW-1:0] addr; logic [DW-1:0] data; logic [BEW-1:0] be; } wr_exp_t;
   typedef struct { int host; logic [DW-1:0] data; } rd_exp_t;
   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];
   wr_exp_t we;
   rd_exp_t re;
   bit sb_en   = 1'b1;
   int wr_seen = 0;
   int rd_seen = 0;

   always @(negedge clk) begin
      if (sb_en && !rst) begin
         if (m_write && !m_waitrequest) begin
            wr_seen++;
            if (wr_q.size() == 0) fail_now("wr_unexpected");
            else begin
               we = wr_q.pop_front();
               check_eq("wr_beat", {grant_id, m_address, m_writedata, m_byteenable},
                        {2'(we.host), we.addr, we.data, we.be});
            end
         end
         if (h_readdatavalid != '0) begin
            rd_seen++;
            if (rd_q.size() == 0) fail_now("rd_unexpected");
            else begin
               re = rd_q.pop_front();
               check_eq("rd_beat", {h_readdatavalid, h_readdata}, {3'(1 << re.host), re.data});
            end
         end
         if (!busy)
            check_eq("idle_outputs", {h_waitrequest, h_readdatavalid, m_read, m_write},
                     {3'b111, 3'b000, 1'b0, 1'b0});
      end
   end

   // ---------------- host BFMs ----------------
   task automatic do_write(input int host, input int bc, input logic [AW-1:0] addr, input int nb,
                           input logic [7:0] gap_mask, input logic [7:0] stall_mask, input bit also_read);
      int b = 0, guard = 0, seen0;
      bit gapped = 1'b0, stalled = 1'b0, acc;
      @(posedge clk); #1;
      h_address[host*AW +: AW]     = addr;
      h_burstcount[host*BW +: BW]  = BW'(bc);
      h_byteenable[host*BEW +: BEW] = be_of(host);
      h_read[host] = also_read;
      for (int i = 0; i < nb; i++) begin
         wr_exp_t e;
         e.host = host; e.addr = addr; e.data = wdata(host, i); e.be = be_of(host);
         wr_q.push_back(e);
      end
      seen0 = wr_seen;
      while (b < nb && guard < 200) begin
         guard++;
         if (b < 8 && gap_mask[b] && !gapped) begin
            h_write[host] = 1'b0;
            m_waitrequest = 1'b0;
            gapped = 1'b1;
         end else begin
            h_write[host] = 1'b1;
            h_writedata[host*DW +: DW] = wdata(host, b);
            m_waitrequest = (b < 8) && stall_mask[b] && !stalled;
         end
         @(negedge clk);
         acc = h_write[host] && !h_waitrequest[host];
         if (m_waitrequest) stalled = 1'b1;
         if (b > 0) check_eq("write_grant_held", {busy, grant_id}, {1'b1, 2'(host)});
         @(posedge clk); #1;
         if (acc) begin
            b++;
            gapped  = 1'b0;
            stalled = 1'b0;
         end
      end
      h_write[host] = 1'b0;
      h_read[host]  = 1'b0;
      m_waitrequest = 1'b0;
      if (b < nb) fail_now("write_timeout");
      wr_q.delete();
      @(negedge clk);
      check_eq("write_beats", wr_seen - seen0, nb);
      check_eq("write_done_busy", busy, 1'b0);
   endtask

   task automatic do_read(input int host, input int bc, input logic [AW-1:0] addr, input int lat, input int nb);
      int guard = 0, seen0;
      bit acc = 1'b0;
      @(posedge clk); #1;
      read_lat = lat;
      h_address[host*AW +: AW]    = addr;
      h_burstcount[host*BW +: BW] = BW'(bc);
      h_read[host] = 1'b1;
      for (int i = 0; i < nb; i++) begin
         rd_exp_t e;
         e.host = host; e.data = rdata(addr, i);
         rd_q.push_back(e);
      end
      seen0 = rd_seen;
      while (!acc && guard < 50) begin
         guard++;
         @(negedge clk);
         acc = !h_waitrequest[host];
         if (acc) check_eq("read_grant", {busy, grant_id}, {1'b1, 2'(host)});
         @(posedge clk); #1;
      end
      h_read[host] = 1'b0;
      if (!acc) fail_now("read_cmd_timeout");
      guard = 0;
      while (acc && rd_seen - seen0 < nb && guard < 300) begin
         guard++;
         @(negedge clk); #1;
         check_eq("read_data_wait", {h_waitrequest, m_read}, {3'b111, 1'b0});
      end
      if (rd_seen - seen0 < nb) fail_now("read_data_timeout");
      rd_q.delete();
      @(negedge clk);
      check_eq("read_done_busy", busy, 1'b0);
   endtask

   // ---------------- vectors ----------------
   typedef struct { int host; int kind; int bc; logic [AW-1:0] addr; int lat; int exp_beats; } vec_t;
   localparam int NV = 8;
   vec_t vecs[NV];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, guard, seen0;
      // kind: 0 = read, 1 = write, 2 = read+write together (write must win)
      vecs[0] = '{1, 1, 4,  32'h0000_1000, 0, 4};
      vecs[1] = '{2, 0, 8,  32'h0000_2000, 5, 8};
      vecs[2] = '{0, 1, 1,  32'h0000_3000, 0, 1};
      vecs[3] = '{0, 0, 0,  32'h0000_4000, 1, 1};
      vecs[4] = '{1, 1, 0,  32'h0000_5000, 0, 1};
      vecs[5] = '{2, 2, 3,  32'h0000_6000, 0, 3};
      vecs[6] = '{1, 0, 63, 32'h0000_7000, 3, 63};
      vecs[7] = '{0, 0, 2,  32'h0000_8000, 1, 2};

      h_address = '0; h_read = '0; h_write = '0; h_writedata = '0;
      h_byteenable = '0; h_burstcount = '0; m_waitrequest = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_state", {busy, grant_id, h_waitrequest, h_readdatavalid, m_read, m_write, fp_busy},
               {1'b0, 2'd0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0});
      rst = 1'b0;

      // stray readdatavalid in IDLE is ignored
      @(posedge clk); #1; stray_rdv = 1'b1;
      @(negedge clk);
      check_eq("stray_idle", {h_readdatavalid, busy}, 4'b0);
      @(posedge clk); #1; stray_rdv = 1'b0;
      @(negedge clk);
      check_eq("stray_idle_after", busy, 1'b0);

      for (int v = 0; v < NV; v++) begin
         if (vecs[v].kind == 0)
            do_read(vecs[v].host, vecs[v].bc, vecs[v].addr, vecs[v].lat, vecs[v].exp_beats);
         else
            do_write(vecs[v].host, vecs[v].bc, vecs[v].addr, vecs[v].exp_beats, 8'h00, 8'h00, vecs[v].kind == 2);
      end

      // write burst with agent stalls on beats 2-3 and host gaps before beats 2 and 4
      do_write(1, 4, 32'h0000_9000, 4, 8'b0000_1010, 8'b0000_0110, 1'b0);

      // RR vs fixed priority with all hosts issuing continuous 1-beat writes
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      sb_en = 1'b0;
      for (int h = 0; h < N; h++) begin
         h_address[h*AW +: AW]     = AW'(h * 256);
         h_burstcount[h*BW +: BW]  = BW'(1);
         h_byteenable[h*BEW +: BEW] = be_of(h);
         h_writedata[h*DW +: DW]   = wdata(h, 0);
      end
      h_write = 3'b111;
      got = 0; guard = 0;
      while (got < 6 && guard < 100) begin
         guard++;
         @(negedge clk);
         if (m_write && !m_waitrequest) begin
            check_eq("rr_order", {grant_id, m_writedata}, {2'(got % 3), wdata(got % 3, 0)});
            check_eq("fp_order", {fp_m_write, fp_grant_id, fp_m_writedata}, {1'b1, 2'd0, wdata(0, 0)});
            got++;
         end
      end
      if (got < 6) fail_now("rr_timeout");
      @(posedge clk); #1;
      h_write = '0;
      @(negedge clk);
      check_eq("rr_release", {busy, fp_busy}, 2'b00);
      sb_en = 1'b1;

      // reset pulse in the middle of an 8-beat read
      @(posedge clk); #1;
      read_lat = 2;
      h_address[2*AW +: AW]    = 32'h0000_A000;
      h_burstcount[2*BW +: BW] = BW'(8);
      h_read[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_exp_t e;
         e.host = 2; e.data = rdata(32'h0000_A000, i);
         rd_q.push_back(e);
      end
      seen0 = rd_seen;
      guard = 0;
      while (h_read[2] && guard < 50) begin
         guard++;
         @(negedge clk);
         if (!h_waitrequest[2]) begin
            @(posedge clk); #1;
            h_read[2] = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (h_read[2]) fail_now("rst_read_cmd_timeout");
      h_read = '0;
      guard = 0;
      while (rd_seen - seen0 < 3 && guard < 50) begin
         guard++;
         @(negedge clk); #1;
      end
      if (rd_seen - seen0 < 3) fail_now("rst_read_data_timeout");
      rst = 1'b1;
      #1;
      check_eq("reset_mid_read", {busy, grant_id, h_waitrequest, h_readdatavalid, m_read, m_write},
               {1'b0, 2'd0, 3'b111, 3'b000, 1'b0, 1'b0});
      @(posedge clk); #1;
      check_eq("reset_hold", {busy, grant_id, h_waitrequest, h_readdatavalid}, {1'b0, 2'd0, 3'b111, 3'b000});
      rst = 1'b0;
      rd_q.delete();
      got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_readdatavalid) begin
            check_eq("stray_after_reset", {h_readdatavalid, busy}, 4'b0);
            got++;
         end
      end
      check_eq("stray_beats_seen", got, 5);

      // arbiter resumes normally after the abort
      do_read(0, 2, 32'h0000_B000, 1, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
